// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
//   arb_state_e : arbiter FSM states
//   owner_e     : which requester owns the in-flight transaction
//   ERR_RDATA   : read data returned when the response watchdog expires
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IFU,
    OWN_LSU
  } owner_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction fetch unit and the load/store unit.
// One transaction in flight at a time: the winning request is registered, presented to memory
// with a valid/ready handshake, and the response is routed back to its owner. A watchdog
// completes a transaction whose response never arrives.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   ifu_req_valid/ready, ifu_addr   fetch request (read only)
//   ifu_rdata, ifu_rvalid           fetch response (1-cycle pulse)
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_wmask   load/store request
//   lsu_rdata, lsu_rvalid           load data / store done (1-cycle pulse)
//   mem_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask   registered request to memory
//   mem_rdata, mem_rvalid           memory response
//   err_timeout                     sticky watchdog-expiry flag
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              err_timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntMax   = '1;

  arb_state_e        state_q;
  owner_e            owner_q;
  logic              lsu_last_q;
  logic [CntW-1:0]   cnt_q;
  logic              err_q;
  logic              mem_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wen_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [7:0]        mem_wmask_q;

  logic pick_lsu;
  logic in_idle;
  logic grant;
  logic resp_mem;
  logic tmo_hit;
  logic resp_done;

  // LSU wins a tie unless it won the previous grant.
  assign pick_lsu = lsu_req_valid & (~ifu_req_valid | ~lsu_last_q);
  // Gated by rst_n so ready stays low while reset is asserted.
  assign in_idle  = (state_q == IDLE) & rst_n;

  assign ifu_req_ready = in_idle & ifu_req_valid & ~pick_lsu;
  assign lsu_req_ready = in_idle & pick_lsu;
  assign grant         = ifu_req_ready | lsu_req_ready;

  // A response is taken in ISSUE only together with the request handshake.
  assign resp_mem  = ((state_q == WAIT_RESP) & mem_rvalid)
                   | ((state_q == ISSUE) & mem_ready & mem_rvalid);
  // A real response in the same cycle beats the watchdog.
  assign tmo_hit   = (TIMEOUT_CYC != 0) && (state_q == WAIT_RESP) && !mem_rvalid
                     && (cnt_q == CntLimit);
  assign resp_done = resp_mem | tmo_hit;

  assign ifu_rvalid = resp_done & (owner_q == OWN_IFU);
  assign lsu_rvalid = resp_done & (owner_q == OWN_LSU);

  always_comb begin
    ifu_rdata = '0;
    lsu_rdata = '0;
    if (ifu_rvalid) begin
      ifu_rdata = tmo_hit ? DATA_W'(ERR_RDATA) : mem_rdata;
    end
    if (lsu_rvalid) begin
      if (tmo_hit) begin
        lsu_rdata = DATA_W'(ERR_RDATA);
      end else if (!mem_wen_q) begin
        lsu_rdata = mem_rdata;
      end
    end
  end

  assign mem_valid   = mem_valid_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wen     = mem_wen_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wmask   = mem_wmask_q;
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      lsu_last_q  <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q     <= ISSUE;
            owner_q     <= lsu_req_ready ? OWN_LSU : OWN_IFU;
            lsu_last_q  <= lsu_req_ready;
            cnt_q       <= '0;
            mem_valid_q <= 1'b1;
            mem_addr_q  <= lsu_req_ready ? lsu_addr : ifu_addr;
            // Fetches are always plain reads.
            mem_wen_q   <= lsu_req_ready & lsu_wen;
            mem_wdata_q <= lsu_req_ready ? lsu_wdata : '0;
            mem_wmask_q <= lsu_req_ready ? lsu_wmask : 8'h00;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            if (mem_rvalid) begin
              state_q <= IDLE;
              owner_q <= OWN_NONE;
            end else begin
              state_q <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (resp_done) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            if (tmo_hit) begin
              err_q <= 1'b1;
            end
          end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          owner_q <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then randomized
// requesters and memory, all checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned Tmo = 4;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rvalid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rvalid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask, mem_wmask;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid, err_timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_mis = 0;

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (Tmo)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rdata     (ifu_rdata),
    .ifu_rvalid    (ifu_rvalid),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rdata     (lsu_rdata),
    .lsu_rvalid    (lsu_rvalid),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid),
    .err_timeout   (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_busy, m_at_mem, m_lsu, m_wen, m_lsu_last, m_err;
  logic [31:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  int          m_waited;

  bit          e_irdy, e_lrdy, e_mval, e_irv, e_lrv, fire, tmo, any_req, pick_lsu;
  logic [31:0] e_rdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ifu_req_ready", ifu_req_ready, 0);
      chk("rst_lsu_req_ready", lsu_req_ready, 0);
      chk("rst_ifu_rvalid", ifu_rvalid, 0);
      chk("rst_lsu_rvalid", lsu_rvalid, 0);
      chk("rst_ifu_rdata", ifu_rdata, 0);
      chk("rst_lsu_rdata", lsu_rdata, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_wmask", {24'h0, mem_wmask}, 0);
      chk("rst_err_timeout", err_timeout, 0);
      m_busy = 0; m_at_mem = 0; m_lsu_last = 0; m_err = 0; m_waited = 0;
    end else begin
      e_irdy = 0; e_lrdy = 0; e_mval = 0; e_irv = 0; e_lrv = 0;
      fire = 0; tmo = 0; e_rdata = '0;
      any_req  = ifu_req_valid || lsu_req_valid;
      pick_lsu = (ifu_req_valid && lsu_req_valid) ? !m_lsu_last : lsu_req_valid;
      if (!m_busy) begin
        e_irdy = any_req && !pick_lsu;
        e_lrdy = any_req && pick_lsu;
      end else if (!m_at_mem) begin
        e_mval = 1;
        fire   = mem_ready && mem_rvalid;
      end else begin
        fire = mem_rvalid;
        tmo  = !mem_rvalid && (m_waited == Tmo);
      end
      if (fire || tmo) begin
        e_irv   = !m_lsu;
        e_lrv   = m_lsu;
        e_rdata = tmo ? 32'hDEAD_BEEF : ((m_lsu && m_wen) ? 32'h0 : mem_rdata);
      end
      chk("ifu_req_ready", ifu_req_ready, e_irdy);
      chk("lsu_req_ready", lsu_req_ready, e_lrdy);
      chk("mem_valid", mem_valid, e_mval);
      chk("ifu_rvalid", ifu_rvalid, e_irv);
      chk("lsu_rvalid", lsu_rvalid, e_lrv);
      chk("err_timeout", err_timeout, m_err);
      if (e_mval) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wen", mem_wen, m_wen);
        chk("mem_wmask", {24'h0, mem_wmask}, {24'h0, m_wmask});
        if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (e_irv) chk("ifu_rdata", ifu_rdata, e_rdata);
      if (e_lrv) chk("lsu_rdata", lsu_rdata, e_rdata);

      // advance to the state after the coming clock edge
      if (!m_busy) begin
        if (any_req) begin
          m_busy     = 1;
          m_at_mem   = 0;
          m_lsu      = pick_lsu;
          m_lsu_last = pick_lsu;
          m_addr     = pick_lsu ? lsu_addr : ifu_addr;
          m_wen      = pick_lsu && lsu_wen;
          m_wdata    = lsu_wdata;
          m_wmask    = pick_lsu ? lsu_wmask : 8'h00;
        end
      end else if (!m_at_mem) begin
        if (mem_ready) begin
          if (mem_rvalid) m_busy = 0;
          else begin
            m_at_mem = 1;
            m_waited = 0;
          end
        end
      end else begin
        if (fire || tmo) begin
          m_busy = 0;
          if (tmo) m_err = 1;
        end else begin
          m_waited++;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL time_limit: got running, expected finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic clear_inputs();
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    nxt();
    rst_n = 1;
  endtask

  bit mute;

  initial begin
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    nxt();
    rst_n = 1;

    // IFU only fetch
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    @(negedge clk); chk("ifu_only_grant", ifu_req_ready, 1);
    nxt(); ifu_req_valid = 0;
    @(negedge clk);
    chk("ifu_only_mem_valid", mem_valid, 1);
    chk("ifu_only_mem_addr", mem_addr, 32'h8000_0000);
    chk("ifu_only_mem_wen", mem_wen, 0);
    chk("ifu_only_mem_wmask", {24'h0, mem_wmask}, 0);
    nxt(); mem_ready = 1;
    @(negedge clk);
    nxt(); mem_ready = 0;
    @(negedge clk); chk("ifu_only_wait_mem_valid", mem_valid, 0);
    nxt(); mem_rvalid = 1; mem_rdata = 32'h0000_0413;
    @(negedge clk);
    chk("ifu_only_rvalid", ifu_rvalid, 1);
    chk("ifu_only_rdata", ifu_rdata, 32'h0000_0413);
    nxt(); mem_rvalid = 0;
    @(negedge clk); chk("ifu_only_rvalid_pulse", ifu_rvalid, 0);
    nxt();

    // Simultaneous requests alternate, starting with the LSU after reset
    do_reset();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 0;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h1111_0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alt_lsu_ready", lsu_req_ready, (k % 2 == 0));
      chk("alt_ifu_ready", ifu_req_ready, (k % 2 == 1));
      chk("alt_idle_no_mem_valid", mem_valid, 0);
      nxt();
      @(negedge clk);
      chk("alt_mem_addr", mem_addr, (k % 2 == 0) ? 32'h8000_1000 : 32'h8000_0100);
      chk("alt_lsu_rvalid", lsu_rvalid, (k % 2 == 0));
      chk("alt_ifu_rvalid", ifu_rvalid, (k % 2 == 1));
      nxt();
    end
    clear_inputs();

    // LSU store
    lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_2004;
    lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 8'h0F;
    @(negedge clk); chk("store_grant", lsu_req_ready, 1);
    nxt(); lsu_req_valid = 0; mem_ready = 1;
    @(negedge clk);
    chk("store_mem_addr", mem_addr, 32'h8000_2004);
    chk("store_mem_wen", mem_wen, 1);
    chk("store_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("store_mem_wmask", {24'h0, mem_wmask}, 32'h0F);
    nxt(); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("store_rvalid", lsu_rvalid, 1);
    chk("store_rdata_zero", lsu_rdata, 0);
    nxt(); clear_inputs();

    // Watchdog expiry
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    @(negedge clk); chk("tmo_grant", ifu_req_ready, 1);
    nxt(); ifu_req_valid = 0; mem_ready = 1;
    @(negedge clk);
    nxt(); mem_ready = 0;
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      chk("tmo_no_early_rvalid", ifu_rvalid, 0);
      nxt();
    end
    @(negedge clk);
    chk("tmo_rvalid", ifu_rvalid, 1);
    chk("tmo_rdata", ifu_rdata, 32'hDEAD_BEEF);
    nxt();
    @(negedge clk);
    chk("tmo_err_set", err_timeout, 1);
    chk("tmo_rvalid_pulse", ifu_rvalid, 0);
    nxt();
    lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_3000;
    @(negedge clk); chk("after_tmo_grant", lsu_req_ready, 1);
    nxt(); lsu_req_valid = 0; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hA5A5_5A5A;
    @(negedge clk);
    chk("after_tmo_rvalid", lsu_rvalid, 1);
    chk("after_tmo_rdata", lsu_rdata, 32'hA5A5_5A5A);
    nxt(); clear_inputs();
    @(negedge clk);
    chk("same_cycle_no_mem_valid", mem_valid, 0);
    chk("err_sticky", err_timeout, 1);
    nxt();

    // Reset while waiting for a response
    ifu_req_valid = 1; ifu_addr = 32'h8000_0080;
    @(negedge clk);
    nxt(); ifu_req_valid = 0; mem_ready = 1;
    @(negedge clk);
    nxt(); mem_ready = 0;
    @(negedge clk); chk("rst_wait_reached", mem_valid, 0);
    nxt(); rst_n = 0; ifu_req_valid = 1;
    #1;
    chk("rst_async_ready", ifu_req_ready, 0);
    chk("rst_async_err", err_timeout, 0);
    chk("rst_async_rvalid", ifu_rvalid, 0);
    @(negedge clk);
    nxt(); rst_n = 1; ifu_req_valid = 0; mem_rvalid = 1;
    @(negedge clk); chk("rst_no_stale_rvalid", ifu_rvalid, 0);
    nxt(); mem_rvalid = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_00C0;
    @(negedge clk); chk("rst_next_grant", ifu_req_ready, 1);
    nxt(); ifu_req_valid = 0; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("rst_next_rvalid", ifu_rvalid, 1);
    chk("rst_next_rdata", ifu_rdata, 32'h0000_0013);
    nxt(); clear_inputs();

    // Randomized traffic against the model
    mute = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) mute = ~mute;
      rst_n         = ($urandom_range(0, 399) != 0);
      ifu_req_valid = ($urandom_range(0, 2) != 0);
      ifu_addr      = $urandom;
      lsu_req_valid = ($urandom_range(0, 2) != 0);
      lsu_addr      = $urandom;
      lsu_wen       = $urandom_range(0, 1);
      lsu_wdata     = $urandom;
      lsu_wmask     = 8'($urandom);
      mem_ready     = $urandom_range(0, 1);
      mem_rvalid    = !mute && ($urandom_range(0, 2) == 0);
      mem_rdata     = $urandom;
      nxt();
    end
    rst_n = 1;
    clear_inputs();
    repeat (3) nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
